// File: rtl/count_checker_pkg.sv
// Shared types and default constants for the count_checker block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: checker state enum, default parameter values, match counter width.
package count_chk_pkg;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_e;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_ERR_W      = 16;

  // Width of the consecutive-good-step counter; bounds LOCK_COUNT to 1..255.
  localparam int MATCH_W = 8;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: q reflects inc/clr one clock edge later.
// Backpressure: none; inc is ignored once saturated, clr wins over inc.
//
// Ports: clk, rst (async active-low), inc (count one), clr (sync zero), q (count).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Monitors a free-running counter bus and checks every sample is the previous one +1 (mod 2^WIDTH).
// Latency: all outputs registered, reflecting the sample taken at the same edge.
// Backpressure: none; a pure observer, sampling count every clock.
//
// Ports: clk, rst (async active-low), count (bus under test), clear (sync restart, zero err_count),
//        locked (in LOCKED), error (1-cycle pulse per locked mismatch), err_count (saturating),
//        last_good (latest sample that was a correct +1 step).
module count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_good
);

  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);

  chk_state_e         state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;
  logic [WIDTH-1:0]   last_good_q, last_good_d;
  logic               err_inc;

  logic [WIDTH-1:0]   exp_val;
  logic               good;
  logic [MATCH_W-1:0] match_inc;

  // Truncation to WIDTH makes all-ones -> 0 a legal step.
  assign exp_val   = prev_q + 1'b1;
  assign good      = (count == exp_val);
  assign match_inc = match_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    prev_d      = count;
    match_d     = match_q;
    locked_d    = locked_q;
    error_d     = 1'b0;
    last_good_d = last_good_q;
    err_inc     = 1'b0;

    if (clear) begin
      // Sample ignored: prev is not refreshed, last_good kept.
      state_d  = UNSYNC;
      prev_d   = prev_q;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        UNSYNC: begin
          // First sample only seeds prev; there is nothing to compare against yet.
          match_d  = '0;
          locked_d = 1'b0;
          state_d  = ACQUIRE;
        end
        ACQUIRE: begin
          if (good) begin
            match_d     = match_inc;
            last_good_d = count;
            if (match_inc == LOCK_TGT) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (good) begin
            last_good_d = count;
          end else begin
            // Leaving LOCKED here is what limits a burst of bad samples to one error pulse.
            error_d  = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            state_d  = ACQUIRE;
          end
        end
        default: begin
          state_d  = UNSYNC;
          match_d  = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNSYNC;
      prev_q      <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      last_good_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      last_good_q <= last_good_d;
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clear),
    .q   (err_count)
  );

  assign locked    = locked_q;
  assign error     = error_q;
  assign last_good = last_good_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker (WIDTH=32, LOCK_COUNT=4, ERR_W=2).
// Inputs driven 1ns after each rising edge; outputs sampled 1ns after the following edge.
// Expected values are hand-derived from the checker's step rules.
module tb_count_checker;

  logic        clk;
  logic        rst;
  logic [31:0] count;
  logic        clear;
  logic        locked;
  logic        error;
  logic [1:0]  err_count;
  logic [31:0] last_good;

  int n_vec  = 0;
  int n_fail = 0;

  count_checker #(
    .WIDTH      (32),
    .LOCK_COUNT (4),
    .ERR_W      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .clear     (clear),
    .locked    (locked),
    .error     (error),
    .err_count (err_count),
    .last_good (last_good)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present v, let one rising edge sample it, then settle.
  task automatic drive(input logic [31:0] v);
    count = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic lk, input logic er, input logic [1:0] ec);
    check({tag, ".locked"}, {31'd0, locked}, {31'd0, lk});
    check({tag, ".error"}, {31'd0, error}, {31'd0, er});
    check({tag, ".err_count"}, {30'd0, err_count}, {30'd0, ec});
  endtask

  initial begin
    rst   = 1'b0;
    clear = 1'b0;
    count = 32'd0;
    #2;
    expect3("reset", 1'b0, 1'b0, 2'd0);
    check("reset.last_good", last_good, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Acquire from 0: UNSYNC edge, then 4 good steps lock at the edge sampling 4.
    drive(32'd0); expect3("acq0", 1'b0, 1'b0, 2'd0);
    drive(32'd1); expect3("acq1", 1'b0, 1'b0, 2'd0);
    check("acq1.last_good", last_good, 32'd1);
    drive(32'd2);
    drive(32'd3); expect3("acq3", 1'b0, 1'b0, 2'd0);
    drive(32'd4); expect3("acq4", 1'b1, 1'b0, 2'd0);
    drive(32'd5); expect3("acq5", 1'b1, 1'b0, 2'd0);
    check("acq5.last_good", last_good, 32'd5);

    // Skip 12: one error pulse, drop to ACQUIRE, relock after 14,15,16,17.
    for (int v = 6; v <= 11; v++) drive(32'(v));
    expect3("run11", 1'b1, 1'b0, 2'd0);
    drive(32'd13); expect3("skip13", 1'b0, 1'b1, 2'd1);
    check("skip13.last_good", last_good, 32'd11);
    drive(32'd14); expect3("re14", 1'b0, 1'b0, 2'd1);
    drive(32'd15);
    drive(32'd16); expect3("re16", 1'b0, 1'b0, 2'd1);
    drive(32'd17); expect3("re17", 1'b1, 1'b0, 2'd1);

    // Jump near the top (mismatch #2), relock, then wrap through 0.
    drive(32'hFFFF_FFFA); expect3("jump", 1'b0, 1'b1, 2'd2);
    drive(32'hFFFF_FFFB);
    drive(32'hFFFF_FFFC);
    drive(32'hFFFF_FFFD); expect3("topFD", 1'b0, 1'b0, 2'd2);
    drive(32'hFFFF_FFFE); expect3("topFE", 1'b1, 1'b0, 2'd2);
    drive(32'hFFFF_FFFF); expect3("topFF", 1'b1, 1'b0, 2'd2);
    drive(32'h0000_0000); expect3("wrap0", 1'b1, 1'b0, 2'd2);
    drive(32'h0000_0001); expect3("wrap1", 1'b1, 1'b0, 2'd2);
    check("wrap1.last_good", last_good, 32'd1);

    // Hold at 7 for three edges: mismatch #3, single pulse.
    for (int v = 2; v <= 7; v++) drive(32'(v));
    expect3("run7", 1'b1, 1'b0, 2'd2);
    drive(32'd7); expect3("hold1", 1'b0, 1'b1, 2'd3);
    drive(32'd7); expect3("hold2", 1'b0, 1'b0, 2'd3);
    drive(32'd7); expect3("hold3", 1'b0, 1'b0, 2'd3);
    for (int v = 8; v <= 11; v++) drive(32'(v));
    expect3("relock11", 1'b1, 1'b0, 2'd3);

    // Mismatches #4 and #5 (jump, then counter reset to 0): err_count holds at 3.
    drive(32'd20); expect3("sat4", 1'b0, 1'b1, 2'd3);
    for (int v = 21; v <= 24; v++) drive(32'(v));
    expect3("relock24", 1'b1, 1'b0, 2'd3);
    drive(32'd0); expect3("sat5", 1'b0, 1'b1, 2'd3);

    // Relock, then clear: err_count zeroed, last_good kept, sample ignored.
    for (int v = 1; v <= 4; v++) drive(32'(v));
    expect3("relock4", 1'b1, 1'b0, 2'd3);
    clear = 1'b1;
    drive(32'd100); expect3("clear", 1'b0, 1'b0, 2'd0);
    check("clear.last_good", last_good, 32'd4);
    clear = 1'b0;
    // Back in UNSYNC: 101 only seeds prev, so last_good must not move.
    drive(32'd101); expect3("unsync", 1'b0, 1'b0, 2'd0);
    check("unsync.last_good", last_good, 32'd4);
    drive(32'd102);
    drive(32'd103);
    drive(32'd104); expect3("clr104", 1'b0, 1'b0, 2'd0);
    drive(32'd105); expect3("clr105", 1'b1, 1'b0, 2'd0);

    // Give err_count something to lose, relock, then async reset mid-cycle.
    drive(32'd200); expect3("pre_rst", 1'b0, 1'b1, 2'd1);
    for (int v = 201; v <= 204; v++) drive(32'(v));
    expect3("locked204", 1'b1, 1'b0, 2'd1);
    #2;
    rst = 1'b0;
    #1;
    expect3("async_rst", 1'b0, 1'b0, 2'd0);
    check("async_rst.last_good", last_good, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(32'd50);
    drive(32'd51);
    drive(32'd52);
    drive(32'd53); expect3("post53", 1'b0, 1'b0, 2'd0);
    drive(32'd54); expect3("post54", 1'b1, 1'b0, 2'd0);
    check("post54.last_good", last_good, 32'd54);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
